// File: rtl/adc_capture_core.sv
// Multi-channel ADC capture engine: level/edge trigger, pre-trigger circular
// buffer and an Avalon-MM register window for setup and readback.
//
// state | meaning
// IDLE  | no capture in progress
// PRE   | filling the pre-trigger history (PRETRIG samples)
// ARMED | waiting for a trigger hit or FORCE
// POST  | storing post-trigger samples until the buffer is complete
// DONE  | capture complete, DONE_FLAG set
module adc_capture_core #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int DEPTH  = 256,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                  main_clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [NCH*DATA_W-1:0] s_data,
    input  logic [3:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [15:0]           writedata,
    output logic [15:0]           readdata,
    output logic                  irq,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [PW:0]   CNT_LAST = (PW+1)'(DEPTH - 1);
    localparam logic [PW-1:0] PT_MAX   = PW'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, wp_d, start_q, start_d;
    logic [PW-1:0]     pretrig_q, pretrig_d, rd_idx_q, rd_idx_d;
    logic              done_q, done_d, force_pend_q, force_pend_d;
    logic [2:0]        trig_ch_q, trig_ch_d;
    logic              trig_mode_q, trig_mode_d, trig_pol_q, trig_pol_d;
    logic [DATA_W-1:0] trig_lvl_q, trig_lvl_d;
    logic [15:0]       rd_ch_q, rd_ch_d, readdata_q, readdata_d;
    logic [DATA_W-1:0] live_q [NCH];
    logic [DATA_W-1:0] live_d [NCH];
    logic [DATA_W-1:0] sample_mem [NCH][DEPTH];

    logic              wr_ctrl, arm, abort, force_now, capturing, store;
    logic [DATA_W-1:0] trig_x, trig_p, rd_word, live_word;
    logic              trig_ch_ok, hit;
    logic [PW-1:0]     rd_addr;

    assign wr_ctrl   = write && (address == 4'd0);
    assign arm       = wr_ctrl && writedata[0];
    assign abort     = wr_ctrl && writedata[1];
    assign force_now = wr_ctrl && writedata[2];
    assign capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign store     = s_valid && capturing;
    assign rd_addr   = start_q + rd_idx_q;

    assign readdata = readdata_q;
    assign irq      = done_q;
    assign busy     = capturing;

    // Previous valid sample of the trigger channel is its LIVE register.
    always_comb begin
        trig_x     = '0;
        trig_p     = '0;
        trig_ch_ok = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (trig_ch_q == 3'(k)) begin
                trig_x     = s_data[k*DATA_W +: DATA_W];
                trig_p     = live_q[k];
                trig_ch_ok = 1'b1;
            end
        end
        if (!trig_mode_q)
            hit = trig_pol_q ? (trig_x <= trig_lvl_q) : (trig_x >= trig_lvl_q);
        else if (trig_pol_q)
            hit = (trig_p > trig_lvl_q) && (trig_x <= trig_lvl_q);
        else
            hit = (trig_p < trig_lvl_q) && (trig_x >= trig_lvl_q);
        hit = hit && trig_ch_ok;
    end

    always_comb begin
        rd_word   = '0;
        live_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_ch_q == 16'(k))
                rd_word = sample_mem[k][rd_addr];
            if (address[2:0] == 3'(k))
                live_word = live_q[k];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wp_d         = wp_q;
        start_d      = start_q;
        pretrig_d    = pretrig_q;
        rd_idx_d     = rd_idx_q;
        done_d       = done_q;
        force_pend_d = force_pend_q;
        trig_ch_d    = trig_ch_q;
        trig_mode_d  = trig_mode_q;
        trig_pol_d   = trig_pol_q;
        trig_lvl_d   = trig_lvl_q;
        rd_ch_d      = rd_ch_q;
        live_d       = live_q;
        readdata_d   = '0;

        if (s_valid) begin
            for (int k = 0; k < NCH; k++)
                live_d[k] = s_data[k*DATA_W +: DATA_W];
        end

        if (read) begin
            case (address)
                4'd0:    readdata_d = '0;
                4'd1:    readdata_d = {12'd0, done_q, state_q};
                4'd2:    readdata_d = {10'd0, trig_pol_q, trig_mode_q, 1'b0, trig_ch_q};
                4'd3:    readdata_d = 16'(trig_lvl_q);
                4'd4:    readdata_d = 16'(pretrig_q);
                4'd5:    readdata_d = rd_ch_q;
                4'd6:    readdata_d = 16'(rd_idx_q);
                4'd7:    readdata_d = 16'(rd_word);
                default: readdata_d = 16'(live_word);
            endcase
        end
        if (read && (address == 4'd7))
            rd_idx_d = rd_idx_q + 1'b1;

        if (write) begin
            case (address)
                4'd1: if (writedata[3]) done_d = 1'b0;
                4'd2: begin
                    trig_ch_d   = writedata[2:0];
                    trig_mode_d = writedata[4];
                    trig_pol_d  = writedata[5];
                end
                4'd3: trig_lvl_d = writedata[DATA_W-1:0];
                4'd4: pretrig_d  = (32'(writedata) >= DEPTH) ? PT_MAX : writedata[PW-1:0];
                4'd5: rd_ch_d    = writedata;
                4'd6: rd_idx_d   = writedata[PW-1:0];
                default: ;
            endcase
        end

        if (store)
            wp_d = wp_q + 1'b1;

        if (abort) begin
            state_d      = S_IDLE;
            force_pend_d = 1'b0;
        end else if (arm) begin
            state_d      = S_PRE;
            cnt_d        = '0;
            done_d       = 1'b0;
            force_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_PRE: begin
                    if (cnt_q == {1'b0, pretrig_q})
                        state_d = S_ARMED;
                    else if (s_valid)
                        cnt_d = cnt_q + 1'b1;
                end
                S_ARMED: begin
                    // FORCE without a sample waits for the next valid one.
                    if (force_now)
                        force_pend_d = 1'b1;
                    if (s_valid && (hit || force_pend_q || force_now)) begin
                        force_pend_d = 1'b0;
                        start_d      = wp_q - pretrig_q;
                        cnt_d        = {1'b0, pretrig_q} + 1'b1;
                        if (pretrig_q == PT_MAX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (s_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wp_q         <= '0;
            start_q      <= '0;
            pretrig_q    <= '0;
            rd_idx_q     <= '0;
            done_q       <= 1'b0;
            force_pend_q <= 1'b0;
            trig_ch_q    <= '0;
            trig_mode_q  <= 1'b0;
            trig_pol_q   <= 1'b0;
            trig_lvl_q   <= '0;
            rd_ch_q      <= '0;
            readdata_q   <= '0;
            for (int k = 0; k < NCH; k++)
                live_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wp_q         <= wp_d;
            start_q      <= start_d;
            pretrig_q    <= pretrig_d;
            rd_idx_q     <= rd_idx_d;
            done_q       <= done_d;
            force_pend_q <= force_pend_d;
            trig_ch_q    <= trig_ch_d;
            trig_mode_q  <= trig_mode_d;
            trig_pol_q   <= trig_pol_d;
            trig_lvl_q   <= trig_lvl_d;
            rd_ch_q      <= rd_ch_d;
            readdata_q   <= readdata_d;
            live_q       <= live_d;
        end
    end

    // Sample storage has no reset; contents are only meaningful after a capture.
    always_ff @(posedge main_clk) begin
        if (store) begin
            for (int k = 0; k < NCH; k++)
                sample_mem[k][wp_q] <= s_data[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: doc/adc_capture_core.md
# adc_capture_core

Parametrised multi-channel ADC capture engine with a level/edge trigger, pre-trigger circular buffer and Avalon-MM register access. It is the successor to the fixed two-channel ADC front-end register block. It sits between the DCO-domain sample deserialiser, which delivers NCH samples per strobe already retimed to main_clk, and the Qsys Avalon-MM fabric. Software arms a capture, waits for irq, then reads NCH×DEPTH samples back through the register window.

## Interface
- DATA_W, 8, sample width per channel (1..16)
- NCH, 2, channel count (1..8)
- DEPTH, 256, samples per channel in buffer; power of two, 16..4096
- PW = log2(DEPTH), derived, pointer/count width

- main_clk  in  1  sole clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  one sample set present this cycle
- s_data  in  NCH*DATA_W  channel k at bits [k*DATA_W +: DATA_W], unsigned
- address  in  4  Avalon-MM word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  16  write data
- readdata  out  16  read data, registered
- irq  out  1  level interrupt, high while DONE_FLAG set
- busy  out  1  high in PRE, ARMED, POST

## Operation
- Register map (unused bits read 0, DATA_W values zero-extended):
  - 0 CTRL (W): b0 ARM, b1 ABORT, b2 FORCE; all self-clearing pulses. R: returns 0.
  - 1 STATUS (R): b[2:0] state code, b3 DONE_FLAG. W: b3=1 clears DONE_FLAG.
  - 2 TRIG_CFG (RW): b[2:0] channel, b4 mode (0 level, 1 edge), b5 polarity (0 rising/above, 1 falling/below).
  - 3 TRIG_LEVEL (RW): DATA_W bits.
  - 4 PRETRIG (RW): PW bits. A written value ≥ DEPTH is stored as DEPTH-1.
  - 5 RD_CH (RW): channel for buffer readback; values ≥ NCH read as 0 data.
  - 6 RD_IDX (RW): PW bits. Sample index relative to capture start. Auto-increments (mod DEPTH) after each read of reg 7.
  - 7 RD_DATA (R): buffer[RD_CH][(start + RD_IDX) mod DEPTH].
  - 8..15 LIVE[k] (R): most recent sample of channel k-8; 0 if k-8 ≥ NCH.
- Buffer: circular, write pointer wp (PW bits) advances on each s_valid while in PRE/ARMED/POST, wrapping DEPTH-1→0.
- FSM (state codes): IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
  - IDLE/DONE: ARM → PRE; cnt←0; DONE_FLAG←0.
  - PRE: count valid samples. When cnt = PRETRIG → ARMED. PRETRIG=0 goes to ARMED on the next cycle. Triggers are ignored in PRE.
  - ARMED: on trigger hit or FORCE, the current sample is the trigger sample. tp←wp, start←tp−PRETRIG (mod DEPTH), → POST, cnt←PRETRIG+1.
  - POST: each valid increments cnt. Writing sample DEPTH−1 (cnt reaching DEPTH) → DONE, DONE_FLAG←1.
  - ABORT in any state → IDLE, DONE_FLAG unchanged.
  - ARM while busy restarts at PRE.
  - ARM and ABORT in the same write: ABORT wins.
- Trigger hit (evaluated only on s_valid, selected channel x, previous valid sample p, unsigned compare against L):
  - level rising: x ≥ L
  - level falling: x ≤ L
  - edge rising: p < L ∧ x ≥ L
  - edge falling: p > L ∧ x ≤ L
  - p is reset to 0 and is updated on every valid, including in IDLE.
- LIVE registers update on every s_valid regardless of state.

## Timing
- Reset values: readdata=0, irq=0, busy=0, state=IDLE, all CSRs 0, LIVE=0, wp=0, DONE_FLAG=0. Buffer contents are undefined.
- Read latency is 1: readdata is valid the cycle after read=1, and is 0 in any cycle following read=0.
- Writes take effect at the clock edge of the write. An ARM write moves to PRE on that edge, so busy=1 the next cycle.
- The sample that satisfies the trigger is stored at index PRETRIG and is included in the capture.
- irq rises on the cycle after the final sample is stored.
- Reg 7 reads RD_IDX as it was before the auto-increment. Back-to-back reads of reg 7 return consecutive samples.
- A write to RD_IDX in the same cycle as a reg-7 read is not permitted. If it occurs, the write wins.
- Reset asserted mid-capture: immediate return to IDLE and irq drops.

## Test plan
- Reset, then read every register. Expect all 0; reg 1 = 0x0000; irq=0.
- NCH=2, DEPTH=16, PRETRIG=4, edge rising L=0x80 on ch0; feed ramp 0x00,0x10,…; ARM. Expect trigger on 0x80, irq after 11 further valids. RD_IDX=0 then 16 reads of reg 7 return 0x40,0x50,…,0xF0,0x00(wrap),… with 0x80 at index 4.
- FORCE in ARMED with no hit. Expect capture with the forced sample at index PRETRIG and DONE_FLAG=1.
- PRETRIG write 0xFFFF with DEPTH=16. Expect reg 4 reads 15; capture holds 15 pre-samples plus the trigger sample.
- ARM+ABORT in the same write while in POST. Expect state 0 and busy=0 next cycle; the following ARM succeeds.
- Assert rst during POST with s_valid toggling. Expect readdata=0, irq=0, busy=0, LIVE regs 0 until the next valid.
